// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, branch redirect, stall hold and the IF/ID pipeline register.
// Also keeps a saturating count of accepted fetches.
module fetch_stage #(
  parameter int unsigned            WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned            COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [WORD_WIDTH-1:0]  branch_addr,
  output logic [WORD_WIDTH-1:0]  imem_addr,
  input  logic [WORD_WIDTH-1:0]  imem_instruction,
  output logic [WORD_WIDTH-1:0]  if_pc_plus4,
  output logic [WORD_WIDTH-1:0]  if_instruction,
  output logic                   if_valid,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam logic [WORD_WIDTH-1:0]  PC_STEP   = WORD_WIDTH'(4);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] pc_plus4;

  // PC+4 wraps naturally at the word width.
  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = pc;

  // Priority: reset, then redirect (flushes IF/ID), then stall hold, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_pc_plus4    <= '0;
      if_instruction <= '0;
      if_valid       <= 1'b0;
      fetch_count    <= '0;
    end else if (branch_taken) begin
      pc             <= {branch_addr[WORD_WIDTH-1:2], 2'b00};
      if_pc_plus4    <= '0;
      if_instruction <= '0;
      if_valid       <= 1'b0;
    end else if (!freeze) begin
      pc             <= pc_plus4;
      if_pc_plus4    <= pc_plus4;
      if_instruction <= imem_instruction;
      if_valid       <= 1'b1;
      if (fetch_count != COUNT_MAX) begin
        fetch_count <= fetch_count + COUNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic,
// each edge compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned CW = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [CW-1:0] fetch_count;

  logic [31:0] prog [16];

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc, m_pp4, m_ins;
  logic        m_valid;
  int          m_cnt;

  fetch_stage #(.WORD_WIDTH(32), .RESET_PC(RST_PC), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .if_pc_plus4(if_pc_plus4), .if_instruction(if_instruction), .if_valid(if_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Program memory: 16 words at 0..60, zero elsewhere.
  assign imem_instruction = (imem_addr < 32'd64) ? prog[imem_addr[5:2]] : 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd64) return prog[a[5:2]];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, check PC before the edge, step the model, check outputs after it.
  task automatic cycle(input logic r, input logic b, input logic [31:0] ba, input logic f);
    rst = r; branch_taken = b; branch_addr = ba; freeze = f;
    #1;
    check("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = RST_PC; m_pp4 = 0; m_ins = 0; m_valid = 0; m_cnt = 0;
    end else if (b) begin
      m_pc = ba & ~32'h3; m_pp4 = 0; m_ins = 0; m_valid = 0;
    end else if (!f) begin
      m_ins   = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pp4   = m_pc;
      m_valid = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
    check("if_pc_plus4", if_pc_plus4, m_pp4);
    check("if_instruction", if_instruction, m_ins);
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    check("pc_after", imem_addr, m_pc);
  endtask

  initial begin
    prog[0] = 32'hE3A00014;
    for (int i = 1; i < 16; i++) prog[i] = $urandom;
    prog[5] = 32'h0;
    m_pc = 0; m_pp4 = 0; m_ins = 0; m_valid = 0; m_cnt = 0;

    @(negedge clk);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 32'h40, 1);
    check("reset_pc", imem_addr, RST_PC);
    check("reset_valid", 32'(if_valid), 32'd0);

    // Four free-running fetches from the reset PC
    cycle(0, 0, 0, 0);
    check("first_pp4", if_pc_plus4, 32'd4);
    check("first_instr", if_instruction, 32'hE3A00014);
    check("first_valid", 32'(if_valid), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    check("count_after4", 32'(fetch_count), 32'd4);
    check("pc_after4", imem_addr, 32'd16);

    // Stall at PC=8 for three cycles, then release
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("freeze_pc", imem_addr, 32'd8);
    check("freeze_count", 32'(fetch_count), 32'd2);
    check("freeze_pp4", if_pc_plus4, 32'd8);
    cycle(0, 0, 0, 0);
    check("release_instr", if_instruction, prog[2]);
    check("release_pp4", if_pc_plus4, 32'd12);

    // Branch with freeze at once: redirect wins, low bits dropped
    cycle(0, 1, 32'h6, 1);
    check("br_pc", imem_addr, 32'd4);
    check("br_valid", 32'(if_valid), 32'd0);
    check("br_instr", if_instruction, 32'd0);
    check("br_count", 32'(fetch_count), 32'd3);

    // Branch to the top word, then wrap; unpopulated memory reads zero
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0);
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_pp4", if_pc_plus4, 32'h0);
    check("wrap_valid", 32'(if_valid), 32'd1);
    check("wrap_instr", if_instruction, 32'h0);

    // Branch arriving as freeze is released
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h20, 0);
    check("rel_br_pc", imem_addr, 32'h20);
    check("rel_br_valid", 32'(if_valid), 32'd0);

    // Reset and branch together mid-run
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h30, 1);
    check("rstbr_pc", imem_addr, RST_PC);
    check("rstbr_pp4", if_pc_plus4, 32'd0);
    check("rstbr_count", 32'(fetch_count), 32'd0);

    // Counter saturation over 20 advances
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    check("sat_count", 32'(fetch_count), 32'd15);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic r, b, f;
      logic [31:0] ba;
      r  = ($urandom_range(0, 31) == 0);
      b  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 3) == 0);
      ba = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      cycle(r, b, ba, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width of PC, address and instruction words.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset; must be a multiple of 4.
REQ-003 Parameter COUNT_WIDTH, default 32: width of the fetch counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 freeze  input  1  hazard stall; holds PC and IF/ID register.
REQ-007 branch_taken  input  1  redirect request from the execute stage.
REQ-008 branch_addr  input  WORD_WIDTH  redirect target.
REQ-009 imem_addr  output  WORD_WIDTH  byte address to the instruction memory, equal to the current PC.
REQ-010 imem_instruction  input  WORD_WIDTH  combinational instruction-memory read data for imem_addr.
REQ-011 if_pc_plus4  output  WORD_WIDTH  registered PC+4 of the instruction held in IF/ID.
REQ-012 if_instruction  output  WORD_WIDTH  registered instruction word to decode.
REQ-013 if_valid  output  1  IF/ID holds a real fetched instruction.
REQ-014 fetch_count  output  COUNT_WIDTH  number of accepted fetches since reset.

Function
REQ-015 The block SHALL hold a PC register and SHALL drive imem_addr = PC combinationally, with no added latency.
REQ-016 The block SHALL evaluate, each rising edge, in the priority rst > branch_taken > freeze > advance.
REQ-017 On branch_taken, the block SHALL load PC <= {branch_addr[WORD_WIDTH-1:2], 2'b00} (low two bits forced to zero), whatever freeze is.
REQ-018 On branch_taken, the block SHALL flush IF/ID: if_valid <= 0, if_instruction <= 0, if_pc_plus4 <= 0; fetch_count SHALL NOT change.
REQ-019 On freeze without branch_taken, PC, if_pc_plus4, if_instruction, if_valid and fetch_count SHALL all hold their values.
REQ-020 On advance (no rst, branch_taken or freeze), the block SHALL set PC <= PC+4, if_pc_plus4 <= PC+4, if_instruction <= imem_instruction and if_valid <= 1.
REQ-021 PC+4 SHALL wrap modulo 2^WORD_WIDTH: 0xFFFFFFFC advances to 0x00000000.
REQ-022 An all-zero imem_instruction (memory default for unpopulated addresses) SHALL be latched as an ordinary instruction with if_valid=1; the block does no decoding.
REQ-023 Fetch latency SHALL be one cycle: an instruction read at PC during cycle N appears on if_instruction after edge N.
REQ-024 fetch_count SHALL increment by 1 on each advance and SHALL saturate at 2^COUNT_WIDTH-1 without wrapping.
REQ-025 A branch_taken that arrives in the same cycle a freeze is released SHALL follow REQ-017/018; no instruction from the old path SHALL reach IF/ID.

Reset
REQ-026 While rst is high at a rising edge: PC <= RESET_PC, if_pc_plus4 <= 0, if_instruction <= 0, if_valid <= 0, fetch_count <= 0, overriding branch_taken and freeze.
REQ-027 imem_addr SHALL equal RESET_PC in the first cycle after reset is released.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight redirect or held stall state.

Verification
REQ-029 Reset, then 4 free cycles with the program memory: imem_addr = 0,4,8,12; after edge 1, if_pc_plus4=4, if_instruction=0xE3A00014, if_valid=1; fetch_count=4 after edge 4.
REQ-030 Hold freeze for 3 cycles at PC=8: imem_addr stays 8, IF/ID and fetch_count unchanged; on release, the next edge latches the word at 8 with if_pc_plus4=12.
REQ-031 branch_taken=1, branch_addr=0x00000006, freeze=1 at once: next PC=4, if_valid=0, if_instruction=0, fetch_count unchanged.
REQ-032 Branch to 0xFFFFFFFC, then one advance: PC=0x00000000, if_pc_plus4=0x00000000, if_valid=1.
REQ-033 rst and branch_taken both high mid-run: PC=RESET_PC, all IF/ID outputs 0, fetch_count=0.
REQ-034 COUNT_WIDTH=4 and 20 uninterrupted advances: fetch_count reaches 15 and stays at 15.
